ma_store_buffer: RTL and testbench

Parametrised posted-store buffer for the memory-access stage, a successor to the stall-on-every-store data path. It accepts committed stores from MA into a DEPTH-entry FIFO so MA no longer stalls on them, then drains them in order to the data bus as TileLink PutPartialData with one transaction outstanding. Loads are checked against the buffer: a fully covered load is forwarded, a partial overlap stalls, and no overlap lets the load proceed. It also provides a fence drain.

---
 rtl/ma_store_buffer_if.sv | 38 +++
 rtl/ma_store_buffer.sv | 182 ++++++++++++++++++
 tb/tb_ma_store_buffer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ma_store_buffer_if.sv
// MA-side request/forwarding signals plus the TileLink A/D channel subset used by the store buffer.
interface ma_store_buffer_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              clear;
    logic              req_valid;
    logic              req_store;
    logic              req_fence;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [63:0]       req_data;
    logic              stall;
    logic              fwd_hit;
    logic [63:0]       fwd_data;
    logic              load_go;
    logic              empty;
    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_opcode;
    logic [ADDR_W-1:0] a_address;
    logic [7:0]        a_mask;
    logic [63:0]       a_data;
    logic              d_valid;

    modport slave (
        input  clear, req_valid, req_store, req_fence, req_addr, req_size, req_data,
        input  a_ready, d_valid,
        output stall, fwd_hit, fwd_data, load_go, empty,
        output a_valid, a_opcode, a_address, a_mask, a_data
    );

    modport master (
        output clear, req_valid, req_store, req_fence, req_addr, req_size, req_data,
        output a_ready, d_valid,
        input  stall, fwd_hit, fwd_data, load_go, empty,
        input  a_valid, a_opcode, a_address, a_mask, a_data
    );
endinterface

// File: rtl/ma_store_buffer.sv
// Posted-store FIFO for the MA stage: in-order drain as PutPartialData, one outstanding,
// with same-cycle store-to-load forwarding and fence drain.
module ma_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    ma_store_buffer_if.slave  bus
);
    localparam int unsigned TAG_W  = ADDR_W - 3;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned PTR_W1 = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [7:0]       mask;
        logic [63:0]      data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    entry_t           r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    state_t           r_state;
    state_t           w_state_nxt;

    logic [2:0]       w_off;
    logic [7:0]       w_size_mask;
    logic [7:0]       w_req_mask;
    logic [63:0]      w_req_lane;
    logic [TAG_W-1:0] w_req_tag;
    logic             w_full;
    logic             w_empty;
    logic             w_is_store;
    logic             w_is_load;
    logic             w_is_fence;
    logic             w_push;
    logic             w_pop;
    logic             w_a_valid;
    logic             w_match;
    logic [7:0]       w_match_mask;
    logic [63:0]      w_match_data;
    logic             w_cover;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request decode: byte mask and lane-aligned data for the doubleword
    always_comb begin
        w_off = bus.req_addr[2:0];
        case (bus.req_size)
            2'd0:    w_size_mask = 8'h01;
            2'd1:    w_size_mask = 8'h03;
            2'd2:    w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
        w_req_mask = w_size_mask << w_off;
        w_req_lane = bus.req_data << {w_off, 3'b000};
        w_req_tag  = bus.req_addr[ADDR_W-1:3];
    end

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0) && (r_state == S_IDLE);
    assign w_is_fence = bus.req_valid & bus.req_fence;
    assign w_is_store = bus.req_valid & bus.req_store & ~bus.req_fence;
    assign w_is_load  = bus.req_valid & ~bus.req_store & ~bus.req_fence;
    assign w_push     = w_is_store & ~bus.clear & ~w_full;

    // Walk oldest to youngest so the last hit is the youngest matching entry
    always_comb begin
        logic [PTR_W1-1:0] sum;
        logic [PTR_W-1:0]  idx;
        w_match      = 1'b0;
        w_match_mask = '0;
        w_match_data = '0;
        sum          = '0;
        idx          = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            sum = {1'b0, r_head} + PTR_W1'(k);
            if (sum >= PTR_W1'(DEPTH)) begin
                sum = sum - PTR_W1'(DEPTH);
            end
            idx = sum[PTR_W-1:0];
            if (r_valid[idx] && (r_mem[idx].tag == w_req_tag)) begin
                w_match      = 1'b1;
                w_match_mask = r_mem[idx].mask;
                w_match_data = r_mem[idx].data;
            end
        end
    end

    assign w_cover = ((w_match_mask & w_req_mask) == w_req_mask);

    // Stall for a full buffer, a partially covered load, or a fence with work pending
    assign bus.stall    = (w_is_store & w_full)
                        | (w_is_load & w_match & ~w_cover)
                        | (w_is_fence & ~w_empty);
    assign bus.fwd_hit  = w_is_load & w_match & w_cover;
    assign bus.fwd_data = w_match_data;
    assign bus.load_go  = w_is_load & ~w_match;
    assign bus.empty    = w_empty;

    // Drain FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_count != '0)  w_state_nxt = S_REQ;
            S_REQ:   if (bus.a_ready)    w_state_nxt = S_WAIT;
            S_WAIT:  if (bus.d_valid)    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Drain FSM: outputs; the ack only counts while waiting for it
    always_comb begin
        w_a_valid = 1'b0;
        w_pop     = 1'b0;
        case (r_state)
            S_REQ:   w_a_valid = 1'b1;
            S_WAIT:  w_pop     = bus.d_valid;
            default: ;
        endcase
    end

    // Head is stable through REQ because it only advances on the ack
    assign bus.a_valid   = w_a_valid;
    assign bus.a_opcode  = 3'd1;
    assign bus.a_address = {r_mem[r_head].tag, 3'b000};
    assign bus.a_mask    = r_mem[r_head].mask;
    assign bus.a_data    = r_mem[r_head].data;

    // FIFO control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= ptr_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Entry payload; qualified by r_valid so it needs no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{tag: w_req_tag, mask: w_req_mask, data: w_req_lane};
        end
    end

endmodule

// File: tb/tb_ma_store_buffer.sv
// Directed bench for ma_store_buffer (DEPTH=4): drain timing, forwarding, full, fence, reset.
module tb_ma_store_buffer;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ma_store_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    ma_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req;
        bus.req_valid = 1'b0;
        bus.req_store = 1'b0;
        bus.req_fence = 1'b0;
        bus.clear     = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = 2'd0;
        bus.req_data  = '0;
    endtask

    task automatic set_req(input logic st, input logic fe, input logic [63:0] addr,
                           input logic [1:0] size, input logic [63:0] data);
        bus.req_valid = 1'b1;
        bus.req_store = st;
        bus.req_fence = fe;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_data  = data;
    endtask

    // Waits (bounded) for a bus request, records it, then accepts and acks it
    task automatic drain_one(output logic [63:0] addr, output logic [7:0] mask,
                             output logic [63:0] data, output bit ok);
        ok   = 1'b0;
        addr = '0;
        mask = '0;
        data = '0;
        for (int i = 0; i < 20; i++) begin
            if (bus.a_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            addr = bus.a_address;
            mask = bus.a_mask;
            data = bus.a_data;
            bus.a_ready = 1'b1;
            tick();
            bus.a_ready = 1'b0;
            bus.d_valid = 1'b1;
            tick();
            bus.d_valid = 1'b0;
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        bus.a_ready = 1'b0;
        bus.d_valid = 1'b0;
        idle_req();
        tick();
        tick();
        checks++; if (bus.empty !== 1'b1)   begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        checks++; if (bus.a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b want 0", bus.a_valid); end
        checks++; if (bus.stall !== 1'b0)   begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit: got %b want 0", bus.fwd_hit); end
        checks++; if (bus.load_go !== 1'b0) begin errors++; $display("FAIL reset_load_go: got %b want 0", bus.load_go); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_store;
        set_req(1'b1, 1'b0, 64'h1004, 2'd2, 64'hDEADBEEF);
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL single_stall: got %b want 0", bus.stall); end
        tick();
        idle_req();
        #1;
        checks++; if (bus.empty !== 1'b0)   begin errors++; $display("FAIL single_n1_empty: got %b want 0", bus.empty); end
        checks++; if (bus.a_valid !== 1'b0) begin errors++; $display("FAIL single_n1_a_valid: got %b want 0", bus.a_valid); end
        tick();
        checks++; if (bus.a_valid !== 1'b1)             begin errors++; $display("FAIL single_n2_a_valid: got %b want 1", bus.a_valid); end
        checks++; if (bus.a_address !== 64'h1000)        begin errors++; $display("FAIL single_a_address: got %h want 1000", bus.a_address); end
        checks++; if (bus.a_mask !== 8'hF0)              begin errors++; $display("FAIL single_a_mask: got %h want f0", bus.a_mask); end
        checks++; if (bus.a_data !== 64'hDEADBEEF_00000000) begin errors++; $display("FAIL single_a_data: got %h want deadbeef00000000", bus.a_data); end
        checks++; if (bus.a_opcode !== 3'd1)             begin errors++; $display("FAIL single_a_opcode: got %0d want 1", bus.a_opcode); end
        tick();
        checks++; if (bus.a_valid !== 1'b1 || bus.a_mask !== 8'hF0) begin errors++; $display("FAIL single_hold: got valid %b mask %h want 1 f0", bus.a_valid, bus.a_mask); end
        bus.a_ready = 1'b1;
        tick();
        bus.a_ready = 1'b0;
        #1;
        checks++; if (bus.a_valid !== 1'b0) begin errors++; $display("FAIL single_wait_a_valid: got %b want 0", bus.a_valid); end
        checks++; if (bus.empty !== 1'b0)   begin errors++; $display("FAIL single_wait_empty: got %b want 0", bus.empty); end
        bus.d_valid = 1'b1;
        tick();
        bus.d_valid = 1'b0;
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_done_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_forward;
        logic [63:0] a, d;
        logic [7:0]  m;
        bit          ok;
        set_req(1'b1, 1'b0, 64'h2000, 2'd3, 64'h1111_1111_1111_1111);
        tick();
        set_req(1'b1, 1'b0, 64'h2000, 2'd0, 64'hAB);
        tick();
        set_req(1'b0, 1'b0, 64'h2000, 2'd3, 64'h0);
        #1;
        checks++; if (bus.stall !== 1'b1)   begin errors++; $display("FAIL fwd_partial_stall: got %b want 1", bus.stall); end
        checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_partial_hit: got %b want 0", bus.fwd_hit); end
        checks++; if (bus.load_go !== 1'b0) begin errors++; $display("FAIL fwd_partial_go: got %b want 0", bus.load_go); end
        set_req(1'b0, 1'b0, 64'h2000, 2'd0, 64'h0);
        #1;
        checks++; if (bus.fwd_hit !== 1'b1)      begin errors++; $display("FAIL fwd_full_hit: got %b want 1", bus.fwd_hit); end
        checks++; if (bus.fwd_data !== 64'hAB)   begin errors++; $display("FAIL fwd_full_data: got %h want ab", bus.fwd_data); end
        checks++; if (bus.stall !== 1'b0)        begin errors++; $display("FAIL fwd_full_stall: got %b want 0", bus.stall); end
        idle_req();
        drain_one(a, m, d, ok);
        checks++; if (!ok || a !== 64'h2000 || m !== 8'hFF || d !== 64'h1111_1111_1111_1111) begin errors++; $display("FAIL fwd_drain0: got ok %b %h %h %h want 1 2000 ff 1111111111111111", ok, a, m, d); end
        drain_one(a, m, d, ok);
        checks++; if (!ok || a !== 64'h2000 || m !== 8'h01 || d !== 64'hAB) begin errors++; $display("FAIL fwd_drain1: got ok %b %h %h %h want 1 2000 01 ab", ok, a, m, d); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fwd_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_no_overlap;
        logic [63:0] a, d;
        logic [7:0]  m;
        bit          ok;
        set_req(1'b1, 1'b0, 64'h2000, 2'd3, 64'h2222);
        tick();
        set_req(1'b0, 1'b0, 64'h3000, 2'd3, 64'h0);
        #1;
        checks++; if (bus.load_go !== 1'b1) begin errors++; $display("FAIL nomatch_go: got %b want 1", bus.load_go); end
        checks++; if (bus.stall !== 1'b0)   begin errors++; $display("FAIL nomatch_stall: got %b want 0", bus.stall); end
        checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL nomatch_hit: got %b want 0", bus.fwd_hit); end
        bus.req_valid = 1'b0;
        #1;
        checks++; if (bus.load_go !== 1'b0) begin errors++; $display("FAIL novalid_go: got %b want 0", bus.load_go); end
        idle_req();
        drain_one(a, m, d, ok);
        checks++; if (!ok || a !== 64'h2000) begin errors++; $display("FAIL nomatch_drain: got ok %b %h want 1 2000", ok, a); end
    endtask

    task automatic test_lanes;
        logic [63:0] a, d;
        logic [7:0]  m;
        bit          ok;
        set_req(1'b1, 1'b0, 64'h7006, 2'd1, 64'hBEEF);
        tick();
        set_req(1'b0, 1'b0, 64'h7007, 2'd0, 64'h0);
        #1;
        checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 64'hBEEF_0000_0000_0000) begin errors++; $display("FAIL lane_fwd: got %b %h want 1 beef000000000000", bus.fwd_hit, bus.fwd_data); end
        set_req(1'b0, 1'b0, 64'h7004, 2'd2, 64'h0);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lane_partial_stall: got %b want 1", bus.stall); end
        idle_req();
        drain_one(a, m, d, ok);
        checks++; if (!ok || a !== 64'h7000 || m !== 8'hC0 || d !== 64'hBEEF_0000_0000_0000) begin errors++; $display("FAIL lane_drain: got ok %b %h %h %h want 1 7000 c0 beef000000000000", ok, a, m, d); end
    endtask

    task automatic test_clear;
        set_req(1'b1, 1'b0, 64'h8000, 2'd3, 64'h55);
        bus.clear = 1'b1;
        tick();
        idle_req();
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL clear_empty: got %b want 1", bus.empty); end
        tick();
        tick();
        checks++; if (bus.a_valid !== 1'b0) begin errors++; $display("FAIL clear_a_valid: got %b want 0", bus.a_valid); end
    endtask

    task automatic test_full;
        logic [63:0] a, d;
        logic [7:0]  m;
        bit          ok;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 64'('h4000 + 8 * i), 2'd3, 64'(i + 1) * 64'h0101_0101_0101_0101);
            tick();
        end
        set_req(1'b1, 1'b0, 64'h4020, 2'd3, 64'h0505_0505_0505_0505);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", bus.stall); end
        drain_one(a, m, d, ok);
        checks++; if (!ok || a !== 64'h4000) begin errors++; $display("FAIL full_drain_first: got ok %b %h want 1 4000", ok, a); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL full_unstall: got %b want 0", bus.stall); end
        tick();
        idle_req();
        for (int k = 1; k < 5; k++) begin
            drain_one(a, m, d, ok);
            checks++;
            if (!ok || a !== 64'('h4000 + 8 * k) || d !== 64'(k + 1) * 64'h0101_0101_0101_0101) begin
                errors++;
                $display("FAIL full_order_%0d: got ok %b %h %h want 1 %h %h", k, ok, a, d,
                         64'('h4000 + 8 * k), 64'(k + 1) * 64'h0101_0101_0101_0101);
            end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_fence;
        logic [63:0] a, d;
        logic [7:0]  m;
        bit          ok;
        set_req(1'b1, 1'b0, 64'h5000, 2'd3, 64'h1);
        tick();
        set_req(1'b1, 1'b0, 64'h5008, 2'd3, 64'h2);
        tick();
        set_req(1'b0, 1'b1, 64'h0, 2'd0, 64'h0);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL fence_stall0: got %b want 1", bus.stall); end
        drain_one(a, m, d, ok);
        checks++; if (!ok || bus.stall !== 1'b1) begin errors++; $display("FAIL fence_stall1: got ok %b stall %b want 1 1", ok, bus.stall); end
        drain_one(a, m, d, ok);
        checks++; if (!ok || a !== 64'h5008 || bus.stall !== 1'b0) begin errors++; $display("FAIL fence_release: got ok %b %h stall %b want 1 5008 0", ok, a, bus.stall); end
        idle_req();
    endtask

    task automatic test_reset_mid;
        logic [63:0] a, d;
        logic [7:0]  m;
        bit          ok;
        int          n;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 1'b0, 64'('h9000 + 8 * i), 2'd3, 64'(i));
            tick();
        end
        idle_req();
        n = 0;
        while (bus.a_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (bus.a_valid !== 1'b1) begin errors++; $display("FAIL rmid_req_timeout: got %b want 1", bus.a_valid); end
        bus.a_ready = 1'b1;
        tick();
        bus.a_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.empty !== 1'b1)   begin errors++; $display("FAIL rmid_empty: got %b want 1", bus.empty); end
        checks++; if (bus.a_valid !== 1'b0) begin errors++; $display("FAIL rmid_a_valid: got %b want 0", bus.a_valid); end
        set_req(1'b0, 1'b0, 64'h9000, 2'd3, 64'h0);
        #1;
        checks++; if (bus.load_go !== 1'b1 || bus.stall !== 1'b0) begin errors++; $display("FAIL rmid_load: got go %b stall %b want 1 0", bus.load_go, bus.stall); end
        idle_req();
        tick();
        rst_n = 1'b1;
        tick();
        bus.d_valid = 1'b1;
        tick();
        bus.d_valid = 1'b0;
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rmid_late_ack_empty: got %b want 1", bus.empty); end
        tick();
        tick();
        checks++; if (bus.a_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_phantom: got %b want 0", bus.a_valid); end
        set_req(1'b1, 1'b0, 64'h6000, 2'd3, 64'h66);
        tick();
        idle_req();
        drain_one(a, m, d, ok);
        checks++; if (!ok || a !== 64'h6000 || d !== 64'h66) begin errors++; $display("FAIL rmid_after: got ok %b %h %h want 1 6000 66", ok, a, d); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rmid_final_empty: got %b want 1", bus.empty); end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_forward();
        test_no_overlap();
        test_lanes();
        test_clear();
        test_full();
        test_fence();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want finish");
        $fatal(1);
    end

endmodule
